// File: rtl/jpeg_block_sequencer.sv
// Control sequencer for the 8x8-block JPEG datapath. It handles the start/done handshake,
// pulses the datapath reset, streams the coefficient addresses and opens the pipeline windows.
module jpeg_block_sequencer #(
    parameter int NUM_BLOCKS   = 4,
    parameter int PIPE_LATENCY = 83,
    parameter int ZZ_DELAY     = 22,
    parameter int QUANT_OFFSET = 47,
    parameter int BRAM_AW      = 8,
    parameter int CW           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               dp_rst,
    output logic               ce,
    output logic               ce_BRAM_write,
    output logic               ce_zig_zag,
    output logic [5:0]         addr_input,
    output logic [5:0]         addr_quant,
    output logic [BRAM_AW-1:0] addr_BRAM_write,
    output logic               busy,
    output logic               done
);

    localparam int WIN_LEN = NUM_BLOCKS * 64;
    localparam int T_TOTAL = PIPE_LATENCY + ZZ_DELAY + WIN_LEN;

    localparam logic [CW-1:0]      WR_START    = CW'(PIPE_LATENCY);
    localparam logic [CW-1:0]      WR_END      = CW'(PIPE_LATENCY + WIN_LEN);
    localparam logic [CW-1:0]      ZZ_START    = CW'(PIPE_LATENCY + ZZ_DELAY);
    localparam logic [CW-1:0]      LAST_CYC    = CW'(T_TOTAL - 1);
    localparam logic [BRAM_AW-1:0] WR_START_LO = BRAM_AW'(PIPE_LATENCY);
    localparam logic [5:0]         QUANT_OFS   = 6'(QUANT_OFFSET);

    if (WIN_LEN > (1 << BRAM_AW)) begin : g_bram_too_small
        $error("NUM_BLOCKS*64 exceeds the BRAM address space");
    end
    if ((T_TOTAL - 1) >= (1 << CW)) begin : g_cw_too_small
        $error("CW cannot hold the full run length");
    end
    if (BRAM_AW > CW) begin : g_aw_too_wide
        $error("BRAM_AW must not exceed CW");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cyc, cyc_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
        end else begin
            state <= state_next;
            cyc   <= cyc_next;
        end
    end

    // NOTE: defaults come first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        cyc_next   = cyc;
        unique case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = RUN;
                cyc_next   = '0;
            end
            RUN: begin
                if (!hold) begin
                    if (cyc == LAST_CYC) state_next = DONE;
                    else                 cyc_next   = cyc + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic in_run;
    logic advancing;
    logic wr_win;
    logic zz_win;

    assign in_run    = (state == RUN);
    assign advancing = in_run && !hold;
    assign wr_win    = (cyc >= WR_START) && (cyc < WR_END);
    // The zig-zag window always runs to the final RUN cycle, so only its lower bound is decoded.
    assign zz_win    = (cyc >= ZZ_START);

    assign dp_rst        = (state == CLEAR);
    assign busy          = (state == CLEAR) || in_run;
    assign done          = (state == DONE);
    assign ce            = advancing;
    assign ce_BRAM_write = advancing && wr_win;
    assign ce_zig_zag    = advancing && zz_win;

    // Addresses depend only on registered state, so a stall freezes them without extra logic.
    assign addr_input      = in_run ? cyc[5:0] : 6'd0;
    assign addr_quant      = (in_run ? cyc[5:0] : 6'd0) + QUANT_OFS;
    assign addr_BRAM_write = (in_run && wr_win) ? (cyc[BRAM_AW-1:0] - WR_START_LO) : '0;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Self-checking bench for jpeg_block_sequencer: a hand-computed vector table, directed
// multi-cycle runs (nominal, stall, start filtering, abort) and random traffic against a timeline model.
module tb_jpeg_block_sequencer;

    localparam int NB = 4;
    localparam int PL = 83;
    localparam int ZZ = 22;
    localparam int QO = 47;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int T  = PL + ZZ + NB * 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic          dp_rst;
    logic          ce;
    logic          ce_BRAM_write;
    logic          ce_zig_zag;
    logic [5:0]    addr_input;
    logic [5:0]    addr_quant;
    logic [AW-1:0] addr_BRAM_write;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    jpeg_block_sequencer #(
        .NUM_BLOCKS  (NB),
        .PIPE_LATENCY(PL),
        .ZZ_DELAY    (ZZ),
        .QUANT_OFFSET(QO),
        .BRAM_AW     (AW),
        .CW          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .hold           (hold),
        .dp_rst         (dp_rst),
        .ce             (ce),
        .ce_BRAM_write  (ce_BRAM_write),
        .ce_zig_zag     (ce_zig_zag),
        .addr_input     (addr_input),
        .addr_quant     (addr_quant),
        .addr_BRAM_write(addr_BRAM_write),
        .busy           (busy),
        .done           (done)
    );

    int checks = 0;
    int errors = 0;

    // Model timeline position: -1 idle, 0 clear, 1..T run cycle (pos-1), T+1 done.
    int pos        = -1;
    int cycle_no   = 0;
    int start_edge = 0;
    int done_edge  = -1;
    int done_count = 0;
    int zz_count   = 0;
    int wr_count[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {dp_rst, ce, ce_BRAM_write, ce_zig_zag, busy, done, addr_input, addr_quant, addr_BRAM_write}
    function automatic logic [25:0] observed();
        return {dp_rst, ce, ce_BRAM_write, ce_zig_zag, busy, done,
                addr_input, addr_quant, addr_BRAM_write};
    endfunction

    function automatic logic [25:0] model_out(input int p, input bit h);
        bit       m_dp_rst = 0, m_ce = 0, m_bw = 0, m_zz = 0, m_busy = 0, m_done = 0;
        logic [5:0] m_ai = 6'd0;
        logic [5:0] m_aq = 6'(QO);
        logic [7:0] m_ab = 8'd0;
        int  c;
        bit  win;
        if (p == 0) begin
            m_dp_rst = 1;
            m_busy   = 1;
        end else if (p >= 1 && p <= T) begin
            c      = p - 1;
            win    = (c >= PL) && (c < PL + NB * 64);
            m_busy = 1;
            m_ce   = !h;
            m_bw   = !h && win;
            m_zz   = !h && (c >= PL + ZZ) && (c < T);
            m_ai   = 6'(c % 64);
            m_aq   = 6'((c + QO) % 64);
            m_ab   = win ? 8'((c - PL) % 256) : 8'd0;
        end else if (p == T + 1) begin
            m_done = 1;
        end
        return {m_dp_rst, m_ce, m_bw, m_zz, m_busy, m_done, m_ai, m_aq, m_ab};
    endfunction

    task automatic model_step(input bit s, input bit h, input bit r);
        if (r) begin
            pos = -1;
        end else if (pos == -1) begin
            if (s) begin
                pos        = 0;
                start_edge = cycle_no;
            end
        end else if (pos == 0) begin
            pos = 1;
        end else if (pos <= T) begin
            if (!h) pos = pos + 1;
        end else begin
            pos = -1;
        end
    endtask

    task automatic tick_inputs(input bit s, input bit h, input bit r);
        start = s;
        hold  = h;
        rst   = r;
        @(negedge clk);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        cycle_no++;
        model_step(start, hold, rst);
        #1;
    endtask

    task automatic cyc_check(input bit s, input bit h, input bit r, output logic [25:0] obs);
        tick_inputs(s, h, r);
        obs = observed();
        check($sformatf("outputs cycle=%0d pos=%0d hold=%0d", cycle_no, pos, h),
              {6'b0, obs}, {6'b0, model_out(pos, h)});
        if (ce_BRAM_write === 1'b1) wr_count[addr_BRAM_write]++;
        if (ce_zig_zag === 1'b1) zz_count++;
        if (done === 1'b1) begin
            done_count++;
            done_edge = cycle_no;
        end
        clock_edge();
    endtask

    // One run from IDLE; optional stall, abort and start pokes keyed to the run cycle.
    task automatic do_run(input int hold_at, input int hold_len, input int abort_at,
                          input bit poke, output int lat);
        int          held    = 0;
        bit          aborted = 0;
        int          n       = 0;
        int          c;
        bit          in_run, s, h, r;
        logic [25:0] obs;
        done_count = 0;
        zz_count   = 0;
        done_edge  = -1;
        foreach (wr_count[i]) wr_count[i] = 0;
        cyc_check(1, 0, 0, obs);
        cyc_check(0, 0, 0, obs);
        check("clear_after_start", {31'b0, obs[25]}, 1);
        while (pos != -1 && n < 2000) begin
            in_run = (pos >= 1) && (pos <= T);
            c      = pos - 1;
            s = 0; h = 0; r = 0;
            if (in_run && c == hold_at && held < hold_len) begin
                h = 1;
                held++;
            end
            if (in_run && c == abort_at && !aborted) begin
                r       = 1;
                aborted = 1;
            end
            if (poke && ((in_run && (c == 150 || c == T - 1)) || pos == T + 1)) s = 1;
            cyc_check(s, h, r, obs);
            n++;
        end
        if (n >= 2000) check("run_cycle_bound", n, 0);
        lat = (done_edge >= 0) ? (done_edge - start_edge) : -1;
    endtask

    function automatic int bram_misses();
        int bad = 0;
        foreach (wr_count[i]) if (wr_count[i] != 1) bad++;
        return bad;
    endfunction

    typedef struct {
        bit         rst;
        bit         start;
        bit         hold;
        bit         e_dp_rst;
        bit         e_busy;
        bit         e_done;
        bit         e_ce;
        logic [5:0] e_ai;
        logic [5:0] e_aq;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          lat;
        logic [25:0] obs;

        // rst start hold | dp_rst busy done ce | addr_input addr_quant
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 6'd0, 6'd47};  // reset state
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 6'd0, 6'd47};  // rst beats start
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 6'd0, 6'd47};  // still idle
        vecs[3]  = '{0, 1, 1, 0, 0, 0, 0, 6'd0, 6'd47};  // start accepted, hold irrelevant
        vecs[4]  = '{0, 0, 1, 1, 1, 0, 0, 6'd0, 6'd47};  // CLEAR ignores hold
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 1, 6'd0, 6'd47};  // cyc0
        vecs[6]  = '{0, 0, 1, 0, 1, 0, 0, 6'd1, 6'd48};  // cyc1 stalled
        vecs[7]  = '{0, 1, 1, 0, 1, 0, 0, 6'd1, 6'd48};  // stalled, start ignored
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 1, 6'd1, 6'd48};  // cyc1 resumes
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 1, 6'd2, 6'd49};  // cyc2
        vecs[10] = '{1, 0, 0, 0, 1, 0, 1, 6'd3, 6'd50};  // cyc3, abort requested
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 6'd0, 6'd47};  // back to idle, no done

        start = 0;
        hold  = 0;
        rst   = 1;
        repeat (2) @(posedge clk);
        #1;
        pos = -1;

        foreach (vecs[i]) begin
            tick_inputs(vecs[i].start, vecs[i].hold, vecs[i].rst);
            check($sformatf("vector %0d", i),
                  {16'b0, dp_rst, busy, done, ce, addr_input, addr_quant},
                  {16'b0, vecs[i].e_dp_rst, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ce,
                   vecs[i].e_ai, vecs[i].e_aq});
            clock_edge();
        end

        // Nominal run.
        do_run(-1, 0, -1, 0, lat);
        check("nominal_done_latency", lat, T + 1);
        check("nominal_done_count", done_count, 1);
        check("nominal_bram_once", bram_misses(), 0);
        check("nominal_zz_cycles", zz_count, NB * 64);

        // Five-cycle stall at cyc100.
        do_run(100, 5, -1, 0, lat);
        check("stall_done_latency", lat, T + 1 + 5);
        check("stall_done_count", done_count, 1);
        check("stall_bram_once", bram_misses(), 0);
        check("stall_zz_cycles", zz_count, NB * 64);

        // Start pokes during RUN and DONE are ignored.
        do_run(-1, 0, -1, 1, lat);
        check("filter_done_count", done_count, 1);
        check("filter_done_latency", lat, T + 1);

        // Abort at cyc200, then a fresh full run.
        do_run(-1, 0, 200, 0, lat);
        check("abort_no_done", done_count, 0);
        cyc_check(0, 0, 0, obs);
        check("abort_idle_busy", {31'b0, obs[21]}, 0);
        check("abort_idle_ce", {31'b0, obs[24]}, 0);
        check("abort_idle_addr_quant", {26'b0, obs[13:8]}, QO);
        do_run(-1, 0, -1, 0, lat);
        check("after_abort_latency", lat, T + 1);
        check("after_abort_done_count", done_count, 1);
        check("after_abort_bram_once", bram_misses(), 0);

        // Random traffic against the timeline model.
        for (int k = 0; k < 3000; k++) begin
            cyc_check($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 499) == 0, obs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
